// File: rtl/jt1943_objbuf.sv
// jt1943_objbuf
// Double-buffered object line buffer feeding the colour mixer.
// The draw engine fills one bank with the next scanline while the other
// bank is read out in step with the pixel counter. Each location that is
// displayed is cleared right after it is read, so the bank is empty when it
// becomes the write bank again. The banks swap at the start of every
// horizontal blank.
//
// Ports
//   clk      system clock, at least twice the cen6 rate
//   rst_n    asynchronous reset, active low
//   cen6     pixel clock enable
//   LHBL     line active (low = horizontal blank)
//   LVBL     frame active (low = vertical blank)
//   flip     screen flip, reads from ~hdump
//   hdump    display pixel counter
//   wr_en    draw engine write strobe
//   wr_addr  x position in the write bank
//   wr_data  pixel from the draw engine {palette, colour}
//   busy     high while both banks are being cleared after reset
//   obj_pxl  pixel to the colour mixer, one cen6 tick after hdump
module jt1943_objbuf #(
   parameter int              AW    = 8,
   parameter int              DW    = 8,
   parameter logic [DW-1:0]   BLANK = 8'hFF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          cen6,
   input  logic          LHBL,
   input  logic          LVBL,
   input  logic          flip,
   input  logic [AW-1:0] hdump,
   input  logic          wr_en,
   input  logic [AW-1:0] wr_addr,
   input  logic [DW-1:0] wr_data,
   output logic          busy,
   output logic [DW-1:0] obj_pxl
);

   typedef enum logic {INIT, RUN} state_t;

   state_t        state_q, state_d;
   logic [AW:0]   init_cnt;
   logic          init_we;
   logic          run;

   logic          bank_sel;
   logic          lhbl_l;

   logic [AW-1:0] ra;
   logic [AW-1:0] clr_addr;
   logic          rd_bank;
   logic          active_l;
   logic          clr_pend;
   logic          clr_we;
   logic          draw_we;

   logic [DW-1:0] mem0 [0:(2**AW)-1];
   logic [DW-1:0] mem1 [0:(2**AW)-1];
   logic [DW-1:0] rd0, rd1;

   logic          we0, we1;
   logic [AW-1:0] wa0, wa1;
   logic [DW-1:0] wd0, wd1;

   assign run = (state_q == RUN);
   assign ra  = flip ? ~hdump : hdump;

   // State register for the clear-then-run sequencer
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= INIT;
      else        state_q <= state_d;
   end

   // INIT walks a counter across both banks (top bit picks the bank) and
   // hands over to RUN once the last address of the second bank is written
   always_comb begin
      state_d = state_q;
      busy    = 1'b0;
      init_we = 1'b0;
      case (state_q)
         INIT: begin
            busy    = 1'b1;
            init_we = 1'b1;
            if (init_cnt == {(AW+1){1'b1}}) state_d = RUN;
         end
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   // Clear counter, restarted by every reset
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               init_cnt <= '0;
      else if (state_q == INIT) init_cnt <= init_cnt + 1'b1;
   end

   // Bank swap on the falling edge of LHBL as seen at the pixel rate.
   // lhbl_l resets low so a blank held through reset does not cause a swap.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lhbl_l   <= 1'b0;
         bank_sel <= 1'b0;
      end else if (cen6) begin
         lhbl_l <= LHBL;
         if (lhbl_l && !LHBL) bank_sel <= ~bank_sel;
      end
   end

   // Read pipeline: each tick remembers what was read and from which bank,
   // then presents it on the next tick. The bank is captured here so that a
   // clear still pending across a swap lands in the bank that was read.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         clr_addr <= '0;
         rd_bank  <= 1'b0;
         active_l <= 1'b0;
         clr_pend <= 1'b0;
         obj_pxl  <= BLANK;
      end else if (cen6) begin
         clr_addr <= ra;
         rd_bank  <= bank_sel;
         active_l <= run && LHBL && LVBL;
         clr_pend <= run && LHBL && LVBL;
         if (run && active_l) obj_pxl <= rd_bank ? rd1 : rd0;
         else                 obj_pxl <= BLANK;
      end else if (clr_pend) begin
         clr_pend <= 1'b0;
      end
   end

   // Clear-behind uses the clk after a tick; draw writes with a transparent
   // colour nibble are dropped so underlying pixels survive
   assign clr_we  = run && clr_pend && !cen6;
   assign draw_we = run && wr_en && (wr_data[3:0] != 4'hF);

   // Per-bank write port selection. The write bank is always the one not
   // being read, so draw writes and clear-behind normally never share a bank.
   always_comb begin
      we0 = 1'b0;
      wa0 = '0;
      wd0 = BLANK;
      we1 = 1'b0;
      wa1 = '0;
      wd1 = BLANK;
      if (init_we) begin
         if (!init_cnt[AW]) begin
            we0 = 1'b1;
            wa0 = init_cnt[AW-1:0];
         end else begin
            we1 = 1'b1;
            wa1 = init_cnt[AW-1:0];
         end
      end else begin
         if (clr_we && !rd_bank) begin
            we0 = 1'b1;
            wa0 = clr_addr;
         end else if (draw_we && bank_sel) begin
            we0 = 1'b1;
            wa0 = wr_addr;
            wd0 = wr_data;
         end
         if (clr_we && rd_bank) begin
            we1 = 1'b1;
            wa1 = clr_addr;
         end else if (draw_we && !bank_sel) begin
            we1 = 1'b1;
            wa1 = wr_addr;
            wd1 = wr_data;
         end
      end
   end

   // Bank 0: simple dual-port RAM, synchronous read on the pixel tick
   always_ff @(posedge clk) begin
      if (we0)  mem0[wa0] <= wd0;
      if (cen6) rd0 <= mem0[ra];
   end

   // Bank 1: simple dual-port RAM, synchronous read on the pixel tick
   always_ff @(posedge clk) begin
      if (we1)  mem1[wa1] <= wd1;
      if (cen6) rd1 <= mem1[ra];
   end

endmodule

// File: tb/tb_jt1943_objbuf.sv
// Bench for jt1943_objbuf. Pixel ticks are one clk in four; every scenario
// tracks which bank is displayed and compares captured lines against
// hand-built expected lines.
module tb_jt1943_objbuf;

   logic       clk, rst_n, cen6, LHBL, LVBL, flip, wr_en, busy;
   logic [7:0] hdump, wr_addr, wr_data, obj_pxl;

   int errors = 0;
   int checks = 0;

   logic [7:0] line_buf [256];
   logic [7:0] exp_line [256];

   jt1943_objbuf dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .cen6    (cen6),
      .LHBL    (LHBL),
      .LVBL    (LVBL),
      .flip    (flip),
      .hdump   (hdump),
      .wr_en   (wr_en),
      .wr_addr (wr_addr),
      .wr_data (wr_data),
      .busy    (busy),
      .obj_pxl (obj_pxl)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // One pixel tick followed by three idle clks; entered and left at a negedge
   task automatic do_tick();
      cen6 = 1'b1;
      @(negedge clk);
      cen6 = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic wr(input logic [7:0] x, input logic [7:0] d);
      wr_en   = 1'b1;
      wr_addr = x;
      wr_data = d;
      @(negedge clk);
      wr_en   = 1'b0;
   endtask

   // Blank swap with LVBL low so no pixel is consumed
   task automatic swap();
      LVBL  = 1'b0;
      LHBL  = 1'b1;
      hdump = 8'd0;
      do_tick();
      LHBL  = 1'b0;
      do_tick();
      LVBL  = 1'b1;
   endtask

   // Displays a full line, capturing the pixel for each x; the closing blank
   // tick also swaps the banks
   task automatic run_line(input logic lv);
      LVBL = lv;
      LHBL = 1'b1;
      for (int h = 0; h < 256; h++) begin
         hdump = 8'(h);
         do_tick();
         if (h > 0) line_buf[h-1] = obj_pxl;
      end
      LHBL  = 1'b0;
      hdump = 8'd0;
      do_tick();
      line_buf[255] = obj_pxl;
      LVBL = 1'b1;
   endtask

   task automatic blank_exp();
      for (int i = 0; i < 256; i++) exp_line[i] = 8'hFF;
   endtask

   task automatic wait_init(output int n);
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (busy && n < 2000);
      @(negedge clk);
   endtask

   task automatic test_reset();
      int n;
      int bad, fx;
      rst_n = 1'b0;
      repeat (3) @(negedge clk);
      checks++;
      if (obj_pxl !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL reset_pxl: got %h expected ff", obj_pxl);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL reset_busy: got %b expected 1", busy);
      end
      rst_n = 1'b1;
      wait_init(n);
      checks++;
      if (n != 512) begin
         errors++;
         $display("[TB] FAIL init_len: busy lasted %0d clks expected 512", n);
      end
      for (int b = 0; b < 2; b++) begin
         run_line(1'b1);
         blank_exp();
         bad = 0; fx = 0;
         for (int x = 0; x < 256; x++)
            if (line_buf[x] !== exp_line[x]) begin
               if (bad == 0) fx = x;
               bad++;
            end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("[TB] FAIL init_bank%0d: x=%0d got %h expected %h (%0d wrong)",
                     b, fx, line_buf[fx], exp_line[fx], bad);
         end
      end
   endtask

   task automatic test_write_read();
      int bad, fx;
      wr(8'd10, 8'h35);
      swap();
      run_line(1'b1);
      blank_exp();
      exp_line[10] = 8'h35;
      bad = 0; fx = 0;
      for (int x = 0; x < 256; x++)
         if (line_buf[x] !== exp_line[x]) begin
            if (bad == 0) fx = x;
            bad++;
         end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL write_read: x=%0d got %h expected %h (%0d wrong)",
                  fx, line_buf[fx], exp_line[fx], bad);
      end
      checks++;
      if (line_buf[9] !== 8'hFF || line_buf[11] !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL latency: x9=%h x11=%h expected ff ff", line_buf[9], line_buf[11]);
      end
   endtask

   task automatic test_clear_behind();
      int bad, fx;
      swap();
      run_line(1'b1);
      blank_exp();
      bad = 0; fx = 0;
      for (int x = 0; x < 256; x++)
         if (line_buf[x] !== exp_line[x]) begin
            if (bad == 0) fx = x;
            bad++;
         end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL clear_behind: x=%0d got %h expected %h (%0d wrong)",
                  fx, line_buf[fx], exp_line[fx], bad);
      end
   endtask

   task automatic test_transparency();
      int bad, fx;
      wr(8'd10, 8'h35);
      wr(8'd10, 8'h4F);
      wr(8'd11, 8'h72);
      wr(8'd11, 8'h81);
      swap();
      run_line(1'b1);
      blank_exp();
      exp_line[10] = 8'h35;
      exp_line[11] = 8'h81;
      bad = 0; fx = 0;
      for (int x = 0; x < 256; x++)
         if (line_buf[x] !== exp_line[x]) begin
            if (bad == 0) fx = x;
            bad++;
         end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL transparency: x=%0d got %h expected %h (%0d wrong)",
                  fx, line_buf[fx], exp_line[fx], bad);
      end
   endtask

   task automatic test_flip_vblank();
      int bad, fx;
      wr(8'd5, 8'h22);
      swap();
      run_line(1'b0);
      blank_exp();
      bad = 0; fx = 0;
      for (int x = 0; x < 256; x++)
         if (line_buf[x] !== exp_line[x]) begin
            if (bad == 0) fx = x;
            bad++;
         end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL vblank_line: x=%0d got %h expected %h (%0d wrong)",
                  fx, line_buf[fx], exp_line[fx], bad);
      end
      swap();
      flip = 1'b1;
      run_line(1'b1);
      flip = 1'b0;
      exp_line[250] = 8'h22;
      bad = 0; fx = 0;
      for (int x = 0; x < 256; x++)
         if (line_buf[x] !== exp_line[x]) begin
            if (bad == 0) fx = x;
            bad++;
         end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL flip_line: x=%0d got %h expected %h (%0d wrong)",
                  fx, line_buf[fx], exp_line[fx], bad);
      end
   endtask

   task automatic test_back_to_back();
      int bad, fx, n;
      // Write issued on the very clk whose pixel tick swaps the banks
      LVBL  = 1'b0;
      LHBL  = 1'b1;
      hdump = 8'd0;
      do_tick();
      LHBL    = 1'b0;
      wr_en   = 1'b1;
      wr_addr = 8'd20;
      wr_data = 8'h56;
      cen6    = 1'b1;
      @(negedge clk);
      cen6  = 1'b0;
      wr_en = 1'b0;
      repeat (3) @(negedge clk);
      LVBL = 1'b1;
      run_line(1'b1);
      blank_exp();
      exp_line[20] = 8'h56;
      bad = 0; fx = 0;
      for (int x = 0; x < 256; x++)
         if (line_buf[x] !== exp_line[x]) begin
            if (bad == 0) fx = x;
            bad++;
         end
      checks++;
      if (bad != 0) begin
         errors++;
         $display("[TB] FAIL swap_write: x=%0d got %h expected %h (%0d wrong)",
                  fx, line_buf[fx], exp_line[fx], bad);
      end

      // Reset in the middle of a displayed line
      wr(8'd3, 8'h99);
      wr(8'd30, 8'h77);
      swap();
      LVBL = 1'b1;
      LHBL = 1'b1;
      for (int h = 0; h < 5; h++) begin
         hdump = 8'(h);
         do_tick();
      end
      checks++;
      if (obj_pxl !== 8'h99) begin
         errors++;
         $display("[TB] FAIL midline_pxl: got %h expected 99", obj_pxl);
      end
      repeat (5) @(negedge clk);
      checks++;
      if (obj_pxl !== 8'h99) begin
         errors++;
         $display("[TB] FAIL hold_pxl: got %h expected 99", obj_pxl);
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if (obj_pxl !== 8'hFF) begin
         errors++;
         $display("[TB] FAIL rst_mid_pxl: got %h expected ff", obj_pxl);
      end
      checks++;
      if (busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL rst_mid_busy: got %b expected 1", busy);
      end
      LHBL = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      wait_init(n);
      checks++;
      if (n != 512) begin
         errors++;
         $display("[TB] FAIL reinit_len: busy lasted %0d clks expected 512", n);
      end
      for (int b = 0; b < 2; b++) begin
         run_line(1'b1);
         blank_exp();
         bad = 0; fx = 0;
         for (int x = 0; x < 256; x++)
            if (line_buf[x] !== exp_line[x]) begin
               if (bad == 0) fx = x;
               bad++;
            end
         checks++;
         if (bad != 0) begin
            errors++;
            $display("[TB] FAIL reinit_bank%0d: x=%0d got %h expected %h (%0d wrong)",
                     b, fx, line_buf[fx], exp_line[fx], bad);
         end
      end
   endtask

   // Scenarios run in order; bank parity carries over from one to the next
   initial begin
      rst_n   = 1'b0;
      cen6    = 1'b0;
      LHBL    = 1'b0;
      LVBL    = 1'b1;
      flip    = 1'b0;
      wr_en   = 1'b0;
      hdump   = 8'd0;
      wr_addr = 8'd0;
      wr_data = 8'd0;
      @(negedge clk);
      test_reset();
      test_write_read();
      test_clear_behind();
      test_transparency();
      test_flip_vblank();
      test_back_to_back();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
